simple_proc: RTL and testbench

SIMPLE_PROC -- requirements
Module: simple_proc

---
 rtl/simple_proc.sv | 113 +++++++++++
 tb/tb_simple_proc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_proc.sv
// Multi-cycle register-transfer processor: eight registers, one shared bus, and
// a T0..T3 step sequencer executing mv, mvi, add and sub.
module simple_proc #(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic [2:0]        DbgSel,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [DATA_W-1:0] DbgR,
  output logic [1:0]        dbg_step
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  step_t             step;
  logic [8:0]        ir;
  logic [DATA_W-1:0] regs [0:7];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] bus;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_arith;

  assign op       = ir[8:6];
  assign rx       = ir[5:3];
  assign ry       = ir[2:0];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  // Bus source select; the bus idles at zero whenever no transfer is scheduled.
  always_comb begin
    bus  = '0;
    Done = 1'b0;
    case (step)
      T1: begin
        case (op)
          OP_MV:   bus = regs[ry];
          OP_MVI:  bus = DIN;
          OP_ADD,
          OP_SUB:  bus = regs[rx];
          default: bus = '0;
        endcase
        Done = !is_arith;
      end
      T2: if (is_arith) bus = regs[ry];
      T3: begin
        if (is_arith) bus = g;
        Done = is_arith;
      end
      default: begin
        bus  = '0;
        Done = 1'b0;
      end
    endcase
  end

  assign BusWires = bus;
  assign DbgR     = regs[DbgSel];
  assign dbg_step = step;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step <= T0;
      ir   <= '0;
      a    <= '0;
      g    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (step)
        T0: begin
          if (Run) begin
            ir   <= DIN[8:0];
            step <= T1;
          end
        end
        T1: begin
          case (op)
            OP_MV, OP_MVI: begin
              regs[rx] <= bus;
              step     <= T0;
            end
            OP_ADD, OP_SUB: begin
              a    <= bus;
              step <= T2;
            end
            default: step <= T0;
          endcase
        end
        T2: begin
          g    <= (op == OP_SUB) ? (a - bus) : (a + bus);
          step <= T3;
        end
        T3: begin
          regs[rx] <= g;
          step     <= T0;
        end
        default: step <= T0;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_proc.sv
// Bench for simple_proc: instruction-level register model that schedules the
// expected Done/BusWires/DbgR value of every cycle, checked once per cycle.
module tb_simple_proc;

  localparam int W = 16;

  logic         Clock;
  logic         Resetn;
  logic         Run;
  logic [W-1:0] DIN;
  logic [2:0]   DbgSel;
  logic         Done;
  logic [W-1:0] BusWires;
  logic [W-1:0] DbgR;
  logic [1:0]   dbg_step;

  simple_proc #(.DATA_W(W)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .DbgSel(DbgSel),
    .Done(Done), .BusWires(BusWires), .DbgR(DbgR), .dbg_step(dbg_step)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]     mregs [0:7];
  logic [2*W:0]     exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one expected {done, bus, dbg} entry per driven cycle.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      logic [2*W:0] e;
      e = exp_q.pop_front();
      check("done", {15'd0, Done}, {15'd0, e[2*W]});
      check("bus", BusWires, e[2*W-1:W]);
      check("dbgr", DbgR, e[W-1:0]);
    end
  end

  // One clock cycle of stimulus plus the outputs that cycle must show.
  task automatic cycle(input logic run, input logic [W-1:0] din, input logic exp_done,
                       input logic [W-1:0] exp_bus);
    logic [2:0] sel;
    sel    = 3'($urandom_range(0, 7));
    Run    = run;
    DIN    = din;
    DbgSel = sel;
    exp_q.push_back({exp_done, exp_bus, mregs[sel]});
    @(posedge Clock); #1;
  endtask

  function automatic logic [W-1:0] word(input logic [2:0] op, input logic [2:0] rx,
                                       input logic [2:0] ry);
    logic [6:0] junk;
    junk = 7'($urandom);
    return {junk, op, rx, ry};
  endfunction

  // Issues one instruction; Run and DIN are randomized while busy to show they are ignored.
  task automatic exec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                      input logic [W-1:0] imm);
    logic [W-1:0] x, y, r;
    cycle(1'b1, word(op, rx, ry), 1'b0, '0);
    x = mregs[rx];
    y = mregs[ry];
    case (op)
      3'b000: begin
        cycle(1'($urandom), W'($urandom), 1'b1, y);
        mregs[rx] = y;
      end
      3'b001: begin
        cycle(1'($urandom), imm, 1'b1, imm);
        mregs[rx] = imm;
      end
      3'b010, 3'b011: begin
        r = (op == 3'b010) ? W'(x + y) : W'(x - y);
        cycle(1'($urandom), W'($urandom), 1'b0, x);
        cycle(1'($urandom), W'($urandom), 1'b0, y);
        cycle(1'($urandom), W'($urandom), 1'b1, r);
        mregs[rx] = r;
      end
      default: cycle(1'($urandom), W'($urandom), 1'b1, '0);
    endcase
  endtask

  task automatic idle();
    cycle(1'b0, W'($urandom), 1'b0, '0);
  endtask

  // Literal check of a register through DbgR; leaves the DUT idle for one cycle.
  task automatic check_reg(input int idx, input logic [W-1:0] val);
    Run    = 1'b0;
    DbgSel = 3'(idx);
    #1;
    check($sformatf("r%0d", idx), DbgR, val);
  endtask

  task automatic resync();
    Run = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      DbgSel = 3'(i);
      #0.5;
      check($sformatf("%s_r%0d", tag, i), DbgR, '0);
    end
    check({tag, "_done"}, {15'd0, Done}, '0);
    check({tag, "_bus"}, BusWires, '0);
    check({tag, "_step"}, {14'd0, dbg_step}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 16'h0048;
    DbgSel = 3'd0;
    @(posedge Clock); @(posedge Clock); #1;
    check_all_zero("reset");
    resync();
    Resetn = 1'b1;

    // Program: R0 = 10 + 20 - 4
    exec(3'b001, 3'd0, 3'd0, 16'd10);
    exec(3'b001, 3'd7, 3'd0, 16'd20);
    exec(3'b010, 3'd0, 3'd7, '0);
    exec(3'b001, 3'd2, 3'd0, 16'd4);
    exec(3'b011, 3'd0, 3'd2, '0);
    check_reg(0, 16'd26); check_reg(7, 16'd20); check_reg(2, 16'd4);
    resync();

    exec(3'b001, 3'd3, 3'd0, 16'h1234);
    exec(3'b000, 3'd5, 3'd3, '0);
    check_reg(5, 16'h1234); check_reg(3, 16'h1234);
    resync();

    exec(3'b001, 3'd1, 3'd0, 16'h0000);
    exec(3'b001, 3'd4, 3'd0, 16'h0001);
    exec(3'b011, 3'd1, 3'd4, '0);
    check_reg(1, 16'hFFFF);
    resync();
    exec(3'b010, 3'd1, 3'd4, '0);
    check_reg(1, 16'h0000);
    resync();

    exec(3'b001, 3'd6, 3'd0, 16'h8001);
    exec(3'b010, 3'd6, 3'd6, '0);
    check_reg(6, 16'h0002);
    resync();
    exec(3'b000, 3'd6, 3'd6, '0);
    exec(3'b111, 3'd6, 3'd1, '0);
    check_reg(6, 16'h0002);
    resync();
    exec(3'b011, 3'd6, 3'd6, '0);
    check_reg(6, 16'h0000);
    resync();

    // Abort an add in T2 with reset; the sum must never land in R0.
    exec(3'b001, 3'd0, 3'd0, 16'h0100);
    exec(3'b001, 3'd7, 3'd0, 16'h0023);
    cycle(1'b1, word(3'b010, 3'd0, 3'd7), 1'b0, '0);
    cycle(1'b1, W'($urandom), 1'b0, 16'h0100);
    Resetn = 1'b0;
    #0.5;
    check_all_zero("abort");
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    @(posedge Clock); #1;
    Resetn = 1'b1;
    idle();
    idle();
    check_reg(0, 16'h0000);
    resync();

    // Randomized instruction stream with occasional idle gaps.
    for (int n = 0; n < 300; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) idle();
      exec(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), W'($urandom));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
